alu_protocol_checker: RTL and testbench

ALU_PROTOCOL_CHECKER -- requirements
Module: alu_protocol_checker

---
 rtl/alu_chk_pkg.sv | 23 ++
 rtl/sat_counter.sv | 22 ++
 rtl/alu_protocol_checker.sv | 156 +++++++++++++++
 tb/tb_alu_protocol_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU handshake protocol checker.
// Error indices address bits of the fire / err_sticky vectors.
package alu_chk_pkg;

  localparam int unsigned ERR_W = 7;

  localparam int unsigned ERR_DONE_NO_START    = 0;
  localparam int unsigned ERR_DONE_ON_NOP      = 1;
  localparam int unsigned ERR_DONE_WIDTH       = 2;
  localparam int unsigned ERR_TIMEOUT          = 3;
  localparam int unsigned ERR_OP_UNSTABLE      = 4;
  localparam int unsigned ERR_OPERAND_UNSTABLE = 5;
  localparam int unsigned ERR_START_DROP       = 6;

  typedef enum logic [2:0] {
    StIdle,
    StBusy,
    StNop,
    StAck,
    StHung
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_protocol_checker.sv
// Passive checker for a start/done ALU handshake: flags protocol violations as
// registered per-cycle pulses, accumulates them, and counts transactions and error cycles.
module alu_protocol_checker
  import alu_chk_pkg::*;
#(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NOP_OP  = 0,
  parameter int unsigned MAX_LAT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                done,
  input  logic [OP_W-1:0]     op,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2*DATA_W-1:0] result,
  input  logic                clear,
  output logic [ERR_W-1:0]    fire,
  output logic [ERR_W-1:0]    err_sticky,
  output logic [CNT_W-1:0]    txn_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam logic [OP_W-1:0] NopOp  = OP_W'(NOP_OP);
  localparam logic [7:0]      MaxLat = 8'(MAX_LAT);

  state_e            state_q, state_d;
  logic [7:0]        lat_q, lat_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0]  err;
  logic              txn_inc;

  // Result is carried on the port for binding only; nothing about it is checked.
  logic unused_result;
  assign unused_result = ^result;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    err     = '0;
    txn_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == NopOp) begin
            state_d = StNop;
            if (done) err[ERR_DONE_ON_NOP] = 1'b1;
          end else begin
            state_d = StBusy;
            op_d    = op;
            a_d     = A;
            b_d     = B;
            lat_d   = '0;
            if (done) begin
              state_d = StAck;
              txn_inc = 1'b1;
            end
          end
        end else if (done) begin
          err[ERR_DONE_NO_START] = 1'b1;
        end
      end
      StBusy: begin
        if (start) begin
          if (op != op_q) err[ERR_OP_UNSTABLE] = 1'b1;
          if ((A != a_q) || (B != b_q)) err[ERR_OPERAND_UNSTABLE] = 1'b1;
        end
        if (done && start) begin
          state_d = StAck;
          txn_inc = 1'b1;
        end else if (done) begin
          err[ERR_DONE_NO_START] = 1'b1;
          err[ERR_START_DROP]    = 1'b1;
          state_d                = StIdle;
        end else if (!start) begin
          err[ERR_START_DROP] = 1'b1;
          state_d             = StIdle;
        end else if (lat_q >= MaxLat) begin
          // lat counts waited BUSY cycles; done is still accepted at lat == MAX_LAT.
          err[ERR_TIMEOUT] = 1'b1;
          state_d          = StHung;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      StNop: begin
        if (done) err[ERR_DONE_ON_NOP] = 1'b1;
        if (!start) begin
          state_d = StIdle;
          txn_inc = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
        if (done)  err[ERR_DONE_WIDTH] = 1'b1;
        if (start) err[ERR_START_DROP] = 1'b1;
      end
      StHung: begin
        if (!start) begin
          state_d = StIdle;
          if (done) err[ERR_DONE_NO_START] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fire       <= '0;
      err_sticky <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fire       <= err;
      // Sticky tracks fire in lockstep, so an error found during clear survives it.
      err_sticky <= clear ? err : (err_sticky | err);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_txn_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (txn_inc),
    .clear(clear),
    .count(txn_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (|err),
    .clear(clear),
    .count(err_count)
  );

endmodule

// File: tb/tb_alu_protocol_checker.sv
// Directed bench for alu_protocol_checker; a second 2-bit-counter instance checks saturation.
module tb_alu_protocol_checker;

  logic        clk = 1'b0;
  logic        reset, start, done, clear;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic [6:0]  fire, err_sticky;
  logic [15:0] txn_count, err_count;
  logic [6:0]  s_fire, s_sticky;
  logic [1:0]  s_txn, s_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_protocol_checker dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .op(op), .A(a), .B(b),
    .result(result), .clear(clear), .fire(fire), .err_sticky(err_sticky),
    .txn_count(txn_count), .err_count(err_count)
  );

  alu_protocol_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .done(done), .op(op), .A(a), .B(b),
    .result(result), .clear(1'b0), .fire(s_fire), .err_sticky(s_sticky),
    .txn_count(s_txn), .err_count(s_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic d, input logic [2:0] o,
                     input logic [7:0] av, input logic [7:0] bv);
    start = s; done = d; op = o; a = av; b = bv;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; result = '0;
    drv(0, 0, 0, 0, 0);
    #12;
    vectors++;
    if (fire !== 7'd0) begin miscompares++; $display("FAIL reset_fire: got %b want 0", fire); end
    vectors++;
    if (err_sticky !== 7'd0) begin
      miscompares++; $display("FAIL reset_sticky: got %b want 0", err_sticky);
    end
    vectors++;
    if (txn_count !== 16'd0 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_counts: got txn=%0d err=%0d want 0/0", txn_count, err_count);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    drv(1, 0, 1, 3, 4); step();
    drv(1, 0, 1, 3, 4); step();
    drv(1, 1, 1, 3, 4); step();
    drv(0, 0, 1, 3, 4); step();
    vectors++;
    if (fire !== 7'd0) begin miscompares++; $display("FAIL basic_fire: got %b want 0", fire); end
    vectors++;
    if (txn_count !== 16'd1) begin
      miscompares++; $display("FAIL basic_txn: got %0d want 1", txn_count);
    end
    vectors++;
    if (err_count !== 16'd0) begin
      miscompares++; $display("FAIL basic_err: got %0d want 0", err_count);
    end
  endtask

  task automatic test_nop();
    drv(1, 0, 0, 0, 0); step();
    drv(0, 1, 0, 0, 0); step();
    vectors++;
    if (fire !== 7'b0000010) begin
      miscompares++; $display("FAIL nop_fire: got %b want 0000010", fire);
    end
    vectors++;
    if (err_count !== 16'd1 || txn_count !== 16'd2) begin
      miscompares++; $display("FAIL nop_counts: got err=%0d txn=%0d want 1/2", err_count, txn_count);
    end
    drv(0, 0, 0, 0, 0); step();
    vectors++;
    if (fire !== 7'd0) begin miscompares++; $display("FAIL nop_quiet: got %b want 0", fire); end
  endtask

  task automatic test_timeout();
    drv(1, 0, 3, 1, 2); step();
    for (int i = 0; i < 15; i++) step();
    vectors++;
    if (fire !== 7'd0) begin
      miscompares++; $display("FAIL timeout_early: got %b want 0", fire);
    end
    step();
    vectors++;
    if (fire !== 7'b0001000) begin
      miscompares++; $display("FAIL timeout_fire: got %b want 0001000", fire);
    end
    vectors++;
    if (err_count !== 16'd2) begin
      miscompares++; $display("FAIL timeout_err: got %0d want 2", err_count);
    end
    // Still HUNG: a done with start held is neither an error nor a transaction.
    drv(1, 1, 3, 1, 2); step();
    vectors++;
    if (fire !== 7'd0 || txn_count !== 16'd2) begin
      miscompares++; $display("FAIL hung_hold: got fire=%b txn=%0d want 0/2", fire, txn_count);
    end
    drv(0, 0, 3, 1, 2); step();
    drv(1, 1, 1, 0, 0); step();
    vectors++;
    if (txn_count !== 16'd3 || fire !== 7'd0) begin
      miscompares++; $display("FAIL hung_exit: got txn=%0d fire=%b want 3/0", txn_count, fire);
    end
    drv(0, 0, 1, 0, 0); step();
  endtask

  task automatic test_width_unstable();
    drv(1, 0, 1, 0, 0); step();
    drv(1, 1, 1, 0, 0); step();
    drv(1, 1, 1, 0, 0); step();
    vectors++;
    if (fire !== 7'b1000100) begin
      miscompares++; $display("FAIL width_fire: got %b want 1000100", fire);
    end
    drv(0, 0, 1, 0, 0); step();
    drv(1, 0, 1, 5, 6); step();
    drv(1, 0, 2, 5, 6); step();
    vectors++;
    if (fire !== 7'b0010000) begin
      miscompares++; $display("FAIL op_unstable: got %b want 0010000", fire);
    end
    drv(1, 0, 2, 7, 6); step();
    vectors++;
    if (fire !== 7'b0110000) begin
      miscompares++; $display("FAIL operand_unstable: got %b want 0110000", fire);
    end
    drv(1, 1, 1, 5, 6); step();
    drv(0, 0, 1, 5, 6); step();
    vectors++;
    if (fire !== 7'd0 || txn_count !== 16'd5 || err_count !== 16'd5) begin
      miscompares++;
      $display("FAIL unstable_end: got fire=%b txn=%0d err=%0d want 0/5/5", fire, txn_count, err_count);
    end
  endtask

  task automatic test_idle_done_clear();
    drv(0, 1, 0, 0, 0); step();
    vectors++;
    if (fire !== 7'b0000001) begin
      miscompares++; $display("FAIL idle_done: got %b want 0000001", fire);
    end
    vectors++;
    if (err_sticky !== 7'h7f || err_count !== 16'd6) begin
      miscompares++; $display("FAIL sticky_all: got %b err=%0d want 1111111/6", err_sticky, err_count);
    end
    vectors++;
    if (s_txn !== 2'd3 || s_err !== 2'd3) begin
      miscompares++; $display("FAIL saturate: got txn=%0d err=%0d want 3/3", s_txn, s_err);
    end
    drv(0, 0, 0, 0, 0); clear = 1'b1; step(); clear = 1'b0;
    vectors++;
    if (err_sticky !== 7'd0 || txn_count !== 16'd0 || err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clear: got sticky=%b txn=%0d err=%0d want 0/0/0", err_sticky, txn_count, err_count);
    end
  endtask

  task automatic test_back_to_back();
    drv(1, 0, 4, 9, 9); step();
    drv(1, 1, 4, 9, 9); step();
    drv(0, 0, 4, 9, 9); step();
    drv(1, 1, 5, 1, 1); step();
    drv(0, 0, 5, 1, 1); step();
    vectors++;
    if (txn_count !== 16'd2 || fire !== 7'd0 || err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL b2b: got txn=%0d fire=%b err=%0d want 2/0/0", txn_count, fire, err_count);
    end
    drv(1, 0, 1, 0, 0); step();
    drv(0, 0, 1, 0, 0); step();
    vectors++;
    if (fire !== 7'b1000000) begin
      miscompares++; $display("FAIL start_drop: got %b want 1000000", fire);
    end
    drv(1, 0, 1, 0, 0); step();
    drv(0, 1, 1, 0, 0); step();
    vectors++;
    if (fire !== 7'b1000001 || err_count !== 16'd2) begin
      miscompares++; $display("FAIL busy_done_nostart: got %b err=%0d want 1000001/2", fire, err_count);
    end
    drv(0, 1, 0, 0, 0); clear = 1'b1; step(); clear = 1'b0;
    vectors++;
    if (fire !== 7'b0000001 || err_sticky !== 7'b0000001 || err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clear_with_err: got fire=%b sticky=%b err=%0d want 0000001/0000001/0",
               fire, err_sticky, err_count);
    end
    drv(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_reset_mid();
    drv(1, 0, 2, 8, 8); step();
    drv(1, 0, 2, 8, 8); step();
    reset = 1'b1;
    #1;
    vectors++;
    if (fire !== 7'd0 || err_sticky !== 7'd0 || txn_count !== 16'd2) begin
      if (txn_count !== 16'd0 || fire !== 7'd0 || err_sticky !== 7'd0) begin
        miscompares++;
        $display("FAIL async_reset: got fire=%b sticky=%b txn=%0d want 0/0/0", fire, err_sticky, txn_count);
      end
    end
    drv(0, 0, 0, 0, 0); step();
    reset = 1'b0;
    step(); step();
    vectors++;
    if (fire !== 7'd0 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_abandon: got fire=%b err=%0d want 0/0", fire, err_count);
    end
    drv(1, 0, 1, 2, 3); step();
    drv(1, 1, 1, 2, 3); step();
    drv(0, 0, 1, 2, 3); step();
    vectors++;
    if (fire !== 7'd0 || txn_count !== 16'd1) begin
      miscompares++; $display("FAIL post_reset_txn: got fire=%b txn=%0d want 0/1", fire, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nop();
    test_timeout();
    test_width_unstable();
    test_idle_done_clear();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
